// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch stage of the 5-stage MIPS pipeline:
// instruction width, special instruction words, PC increment and fetch FSM states.
package pipeline_pkg;

  localparam int          INSTR_W     = 32;
  localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port for program load and one
// asynchronous read port for fetch. Contents are never reset.
module instr_mem
  import pipeline_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, LOAD/RUN/HALTED FSM and instruction memory.
// Optional cycle counter output o_cycle_count is built when IF_CYCLE_COUNT_EN is defined.
module instruction_fetch_unit #(
  parameter int          MEM_DEPTH   = 256,
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              is_jump_taken,
  input  logic [31:0]       i_jump_addr,
  input  logic              is_write_pc,
  input  logic              i_load_wr_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [31:0]       i_load_data,
  input  logic              i_load_done,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instruction,
  output logic              os_stop_pipe,
  output logic [31:0]       o_cur_pc,
`ifdef IF_CYCLE_COUNT_EN
  output logic [31:0]       o_cycle_count,
`endif
  output logic              o_halted,
  output logic              o_loading
);

  import pipeline_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rd_data;
  logic        fetched_halt;
  logic        mem_wr_en;
  logic [1:0]  unused_jump_low;

  // Jump targets are word aligned; the byte offset bits are discarded.
  assign unused_jump_low = i_jump_addr[1:0];

  assign mem_wr_en = i_load_wr_en && (state_q == ST_LOAD);

  instr_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_instr_mem (
    .clk       (clk),
    .i_wr_en   (mem_wr_en),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    .i_rd_addr (pc_q[ADDR_W+1:2]),
    .o_rd_data (rd_data)
  );

  assign o_loading     = (state_q == ST_LOAD);
  assign o_halted      = (state_q == ST_HALTED);
  assign o_instruction = o_loading ? NOP_WORD : rd_data;
  assign fetched_halt  = (o_instruction == HALT_OPCODE);
  assign os_stop_pipe  = fetched_halt;
  assign o_pc          = pc_q + PC_INC;
  assign o_cur_pc      = pc_q;

`ifdef IF_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  assign o_cycle_count = cycle_cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef IF_CYCLE_COUNT_EN
    cycle_cnt_d = cycle_cnt_q;
`endif
    case (state_q)
      ST_LOAD: begin
        pc_d = '0;
        if (i_load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_step) begin
`ifdef IF_CYCLE_COUNT_EN
          cycle_cnt_d = cycle_cnt_q + 32'd1;
`endif
          // A taken jump flushes the fetched slot, so it beats both stall and HALT.
          if (is_jump_taken) begin
            pc_d = {i_jump_addr[31:2], 2'b00};
          end else if (!is_write_pc) begin
            pc_d = pc_q;
          end else if (fetched_halt) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end
      end
      ST_HALTED: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = ST_LOAD;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
`ifdef IF_CYCLE_COUNT_EN
      cycle_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef IF_CYCLE_COUNT_EN
      cycle_cnt_q <= cycle_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit against a word-level
// reference model; also checks o_cycle_count when IF_CYCLE_COUNT_EN is defined.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        step, jump, wpc, wr_en, ldone;
  logic [31:0] jaddr, ldata;
  logic [7:0]  laddr;
  logic [31:0] o_pc, o_instruction, o_cur_pc;
  logic        os_stop_pipe, o_halted, o_loading;
`ifdef IF_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_step        (step),
    .is_jump_taken (jump),
    .i_jump_addr   (jaddr),
    .is_write_pc   (wpc),
    .i_load_wr_en  (wr_en),
    .i_load_addr   (laddr),
    .i_load_data   (ldata),
    .i_load_done   (ldone),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .os_stop_pipe  (os_stop_pipe),
    .o_cur_pc      (o_cur_pc),
`ifdef IF_CYCLE_COUNT_EN
    .o_cycle_count (o_cycle_count),
`endif
    .o_halted      (o_halted),
    .o_loading     (o_loading)
  );

  // reference model: program image, architectural PC and mode flags
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  bit          m_loading, m_halted;
  logic [31:0] m_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc      = 32'd0;
    m_loading = 1'b1;
    m_halted  = 1'b0;
    m_cnt     = 32'd0;
  endfunction

  // Applies one rising edge with the inputs currently on the bench wires.
  function automatic void model_edge();
    if (m_loading) begin
      if (wr_en) m_mem[laddr] = ldata;
      if (ldone) m_loading = 1'b0;
    end else if (!m_halted && step) begin
      m_cnt = m_cnt + 32'd1;
      if (jump)                          m_pc = jaddr & 32'hFFFF_FFFC;
      else if (!wpc)                     m_pc = m_pc;
      else if (m_mem[m_pc[9:2]] == HALT) m_halted = 1'b1;
      else                               m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] word;
    word = m_loading ? 32'd0 : m_mem[m_pc[9:2]];
    chk({tag, ":cur_pc"}, o_cur_pc, m_pc);
    chk({tag, ":pc"}, o_pc, m_pc + 32'd4);
    chk({tag, ":instr"}, o_instruction, word);
    chk({tag, ":stop"}, {31'd0, os_stop_pipe}, {31'd0, word == HALT});
    chk({tag, ":halted"}, {31'd0, o_halted}, {31'd0, m_halted});
    chk({tag, ":loading"}, {31'd0, o_loading}, {31'd0, m_loading});
`ifdef IF_CYCLE_COUNT_EN
    chk({tag, ":count"}, o_cycle_count, m_cnt);
`endif
  endtask

  // driver tasks
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_run(input logic s, input logic j, input logic [31:0] ja, input logic w);
    step = s; jump = j; jaddr = ja; wpc = w; wr_en = 1'b0; ldone = 1'b0;
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] saved;
    logic [31:0] w;
    step = 0; jump = 0; jaddr = 0; wpc = 1; wr_en = 0; laddr = 0; ldata = 0; ldone = 0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;

    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load whole image with step low; last write and done share a cycle.
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       w = 32'h2001_0005;
        1:       w = 32'h2002_0003;
        2:       w = 32'h0022_1820;
        3:       w = HALT;
        default: begin
          w = $urandom;
          if (w == HALT) w = 32'd0;
        end
      endcase
      wr_en = 1'b1; laddr = i[7:0]; ldata = w; ldone = (i == 255);
      cycle("load");
    end
    chk("run_entered", {31'd0, o_loading}, 32'd0);

    // Straight-line program up to HALT.
    set_run(1, 0, 0, 1);
    exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'd16);
    for (int k = 0; k < 4; k++) begin
      chk("pc_seq", o_pc, exp_q.pop_front());
      if (k == 3) chk("halt_seen", {31'd0, os_stop_pipe}, 32'd1);
      cycle("prog");
    end
    chk("halted", {31'd0, o_halted}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      set_run($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      cycle("halt_hold");
      chk("halt_pc", o_cur_pc, 32'd12);
    end

    // Mid-cycle reset, then place HALT at word 1.
    async_reset();
    set_run(0, 0, 0, 1);
    wr_en = 1'b1; laddr = 8'd1; ldata = HALT;
    cycle("reload");
    wr_en = 1'b0; ldone = 1'b1;
    cycle("done");

    set_run(1, 0, 0, 1);
    cycle("to_halt_word");
    chk("halt_word_stop", {31'd0, os_stop_pipe}, 32'd1);
    set_run(1, 1, 32'h40, 0);
    cycle("jump_over_halt");
    chk("jump_over_pc", o_cur_pc, 32'h40);
    chk("jump_over_halted", {31'd0, o_halted}, 32'd0);

    set_run(1, 1, 32'h8, 1);
    cycle("jump_8");
    set_run(1, 1, 32'h23, 0);
    cycle("jump_align");
    chk("jump_align_pc", o_cur_pc, 32'h20);

    set_run(1, 1, 32'h10, 1);
    cycle("jump_10");
    saved = o_instruction;
    set_run(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      chk("stall_pc", o_cur_pc, 32'h10);
      chk("stall_instr", o_instruction, saved);
    end
    set_run(1, 0, 0, 1);
    cycle("unstall");
    chk("unstall_pc", o_cur_pc, 32'h14);

    for (int k = 0; k < 5; k++) begin
      set_run(0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      cycle("no_step");
      chk("no_step_pc", o_cur_pc, 32'h14);
    end

    // A load write while running must not reach memory.
    saved = m_mem[50];
    set_run(1, 0, 0, 0);
    wr_en = 1'b1; laddr = 8'd50; ldata = ~saved;
    cycle("run_write");
    set_run(1, 1, 32'd200, 1);
    cycle("jump_50");
    chk("run_write_ignored", o_instruction, saved);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      step  = ($urandom_range(0, 3) != 0);
      jump  = ($urandom_range(0, 9) == 0);
      jaddr = $urandom;
      wpc   = ($urandom_range(0, 4) != 0);
      wr_en = $urandom_range(0, 1);
      laddr = $urandom_range(0, 255);
      ldata = $urandom;
      ldone = $urandom_range(0, 1);
      cycle("random");
    end

    // Program survives reset and runs again after done.
    async_reset();
    set_run(0, 0, 0, 1);
    ldone = 1'b1;
    cycle("rerun_done");
    set_run(1, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle("rerun");
    chk("rerun_halted", {31'd0, o_halted}, 32'd1);
    chk("rerun_pc", o_cur_pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
